// File: rtl/stack_transfer_sequencer_pkg.sv
// Shared encodings for the stack transfer sequencer: incrementor control codes,
// FSM states and transfer direction.
package stack_transfer_sequencer_pkg;

  localparam logic [2:0] INC_HOLD = 3'd0;
  localparam logic [2:0] INC_UP   = 3'd1;
  localparam logic [2:0] INC_DOWN = 3'd2;
  localparam logic [2:0] INC_MAX  = 3'd3;
  localparam logic [2:0] INC_LOAD = 3'd4;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ACCESS,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/stack_transfer_sequencer_priority_pick.sv
// Combinational set-bit selector: returns the lowest or highest set bit of a mask.
module priority_pick #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] mask,
  input  logic             lowest_first,
  output logic [3:0]       index,
  output logic             valid
);

  // The last matching bit in loop order wins, so loop direction sets the priority.
  always_comb begin
    index = '0;
    valid = |mask;
    if (lowest_first) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (mask[i]) index = 4'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (mask[i]) index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/stack_transfer_sequencer.sv
// Sequences the SP incrementor for multi-register PUSH/POP, one memory word per
// listed register, with overflow/underflow detection.
module stack_transfer_sequencer
  import stack_transfer_sequencer_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    PACE        = 1,
  parameter int                    LIST_WIDTH  = 9,
  parameter logic [DATA_WIDTH-1:0] STACK_BASE  = 32'h0000_03FF,
  parameter logic [DATA_WIDTH-1:0] STACK_LIMIT = 32'h0000_0200
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op,
  input  logic [LIST_WIDTH-1:0] reg_list,
  input  logic                  sp_load,
  input  logic [DATA_WIDTH-1:0] sp_load_value,
  output logic [2:0]            inc_control,
  output logic [DATA_WIDTH-1:0] inc_input,
  output logic [DATA_WIDTH-1:0] inc_new,
  input  logic [DATA_WIDTH-1:0] inc_result,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic                  mem_ready,
  output logic [3:0]            reg_index,
  output logic [DATA_WIDTH-1:0] sp,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(PACE);

  state_t                state;
  logic                  op_q;
  logic [LIST_WIDTH-1:0] pending;
  logic [3:0]            pick_index;
  logic                  pick_valid;
  logic                  at_limit;

  priority_pick #(.WIDTH(LIST_WIDTH)) u_pick (
    .mask         (pending),
    .lowest_first (op_q),
    .index        (pick_index),
    .valid        (pick_valid)
  );

  assign inc_input = sp;
  assign busy      = (state != ST_IDLE);

  // One more step would leave the legal SP window in the current direction.
  assign at_limit = (op_q == OP_PUSH) ? (sp < STACK_LIMIT + STEP)
                                      : (sp > STACK_BASE - STEP);

  always_comb begin
    inc_control = INC_HOLD;
    inc_new     = '0;
    if (reset) begin
      case (state)
        ST_IDLE: begin
          if (sp_load && !start) begin
            inc_control = INC_LOAD;
            inc_new     = sp_load_value;
          end
        end
        ST_SELECT: begin
          if (pick_valid && op_q == OP_PUSH && !at_limit) inc_control = INC_DOWN;
        end
        ST_ACCESS: begin
          if (mem_ready && op_q == OP_POP) inc_control = INC_UP;
        end
        default: inc_control = INC_HOLD;
      endcase
    end
  end

  // Access address comes from inc_result so a push uses the pre-decremented SP.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sp        <= STACK_BASE;
      op_q      <= OP_PUSH;
      pending   <= '0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      reg_index <= '0;
      done      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (inc_control != INC_HOLD) sp <= inc_result;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            pending <= reg_list;
            fault   <= 1'b0;
            state   <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (!pick_valid) begin
            done  <= 1'b1;
            state <= ST_FINISH;
          end else if (at_limit) begin
            fault <= 1'b1;
            done  <= 1'b1;
            state <= ST_FINISH;
          end else begin
            reg_index <= pick_index;
            mem_addr  <= inc_result;
            mem_write <= (op_q == OP_PUSH);
            mem_read  <= (op_q == OP_POP);
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            pending   <= pending & ~(LIST_WIDTH'(1) << reg_index);
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            state     <= ST_SELECT;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_transfer_sequencer.sv
// Directed self-checking bench for stack_transfer_sequencer with a behavioural
// incrementor and an access log.
module tb_stack_transfer_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [8:0]  reg_list = '0;
  logic        sp_load = 1'b0;
  logic [31:0] sp_load_value = '0;
  logic [2:0]  inc_control;
  logic [31:0] inc_input;
  logic [31:0] inc_new;
  logic [31:0] inc_result;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready = 1'b1;
  logic [3:0]  reg_index;
  logic [31:0] sp;
  logic        busy;
  logic        done;
  logic        fault;

  int compared = 0;
  int mismatched = 0;
  int done_count = 0;
  int read_seen = 0;
  int cycles;
  logic [31:0] log_addr[$];
  logic [3:0]  log_idx[$];
  logic        log_wr[$];

  stack_transfer_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .reg_list(reg_list),
    .sp_load(sp_load), .sp_load_value(sp_load_value), .inc_control(inc_control),
    .inc_input(inc_input), .inc_new(inc_new), .inc_result(inc_result),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ready(mem_ready), .reg_index(reg_index), .sp(sp), .busy(busy),
    .done(done), .fault(fault)
  );

  always #5 clock = ~clock;

  // Behavioural incrementor with PACE = 1.
  always_comb begin
    case (inc_control)
      3'd1:    inc_result = inc_input + 32'd1;
      3'd2:    inc_result = inc_input - 32'd1;
      3'd4:    inc_result = inc_new;
      default: inc_result = inc_input;
    endcase
  end

  // Inputs change just after posedge, so the negedge sees what the next edge will use.
  always @(negedge clock) begin
    if (done) done_count++;
    if (mem_read) read_seen++;
    if ((mem_write || mem_read) && mem_ready) begin
      log_addr.push_back(mem_addr);
      log_idx.push_back(reg_index);
      log_wr.push_back(mem_write);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clearLog();
    log_addr.delete();
    log_idx.delete();
    log_wr.delete();
    done_count = 0;
    read_seen = 0;
  endtask

  task automatic applyStimulus(input logic s, input logic o, input logic [8:0] l,
                               input logic ld, input logic [31:0] v);
    start = s;
    op = o;
    reg_list = l;
    sp_load = ld;
    sp_load_value = v;
    step();
    start = 1'b0;
    sp_load = 1'b0;
  endtask

  // Cycles from the start edge until done is seen; -1 if the budget runs out.
  task automatic waitDone(output int n);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (done) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic checkAccess(input string tag, input int k, input logic wr,
                             input logic [3:0] idx, input logic [31:0] addr);
    if (k < log_addr.size()) begin
      checkOutput({tag, "_wr"}, 32'(log_wr[k]), 32'(wr));
      checkOutput({tag, "_idx"}, 32'(log_idx[k]), 32'(idx));
      checkOutput({tag, "_addr"}, log_addr[k], addr);
    end else begin
      checkOutput({tag, "_present"}, log_addr.size(), k + 1);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    checkOutput("rst_sp", sp, 32'h3FF);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_fault", 32'(fault), 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_reg_index", 32'(reg_index), 0);
    checkOutput("rst_strobes", {30'd0, mem_read, mem_write}, 0);
    checkOutput("rst_inc_control", 32'(inc_control), 0);
    step();
    reset = 1'b1;
    step();

    // Push R0, R1, LR from the empty stack
    clearLog();
    applyStimulus(1'b1, 1'b0, 9'h103, 1'b0, 32'h0);
    waitDone(cycles);
    checkOutput("push_cycles", cycles, 8);
    checkOutput("push_count", log_addr.size(), 3);
    checkAccess("push0", 0, 1'b1, 4'd8, 32'h3FE);
    checkAccess("push1", 1, 1'b1, 4'd1, 32'h3FD);
    checkAccess("push2", 2, 1'b1, 4'd0, 32'h3FC);
    checkOutput("push_sp", sp, 32'h3FC);
    checkOutput("push_inc_input", inc_input, 32'h3FC);
    checkOutput("push_fault", 32'(fault), 0);
    step();
    checkOutput("push_done_pulses", done_count, 1);
    checkOutput("push_idle", 32'(busy), 0);

    // Pop them back, lowest register first
    clearLog();
    applyStimulus(1'b1, 1'b1, 9'h103, 1'b0, 32'h0);
    waitDone(cycles);
    checkOutput("pop_cycles", cycles, 8);
    checkOutput("pop_count", log_addr.size(), 3);
    checkAccess("pop0", 0, 1'b0, 4'd0, 32'h3FC);
    checkAccess("pop1", 1, 1'b0, 4'd1, 32'h3FD);
    checkAccess("pop2", 2, 1'b0, 4'd8, 32'h3FE);
    checkOutput("pop_sp", sp, 32'h3FF);
    step();
    checkOutput("pop_done_pulses", done_count, 1);

    // Overflow: one word fits above STACK_LIMIT, the second faults
    applyStimulus(1'b0, 1'b0, 9'h0, 1'b1, 32'h201);
    checkOutput("load_sp", sp, 32'h201);
    clearLog();
    applyStimulus(1'b1, 1'b0, 9'h007, 1'b0, 32'h0);
    waitDone(cycles);
    checkOutput("ovf_cycles", cycles, 4);
    checkOutput("ovf_count", log_addr.size(), 1);
    checkAccess("ovf0", 0, 1'b1, 4'd2, 32'h200);
    checkOutput("ovf_fault", 32'(fault), 1);
    checkOutput("ovf_sp", sp, 32'h200);
    step();
    checkOutput("ovf_fault_sticky", 32'(fault), 1);

    // Underflow on pop from the empty stack, then an empty start clears fault
    applyStimulus(1'b0, 1'b0, 9'h0, 1'b1, 32'h3FF);
    clearLog();
    applyStimulus(1'b1, 1'b1, 9'h001, 1'b0, 32'h0);
    waitDone(cycles);
    checkOutput("udf_cycles", cycles, 2);
    checkOutput("udf_fault", 32'(fault), 1);
    checkOutput("udf_reads", read_seen, 0);
    checkOutput("udf_sp", sp, 32'h3FF);
    step();
    applyStimulus(1'b1, 1'b0, 9'h000, 1'b0, 32'h0);
    waitDone(cycles);
    checkOutput("empty_cycles", cycles, 2);
    checkOutput("empty_fault_clear", 32'(fault), 0);
    checkOutput("empty_sp", sp, 32'h3FF);

    // Stalled push: request held steady while mem_ready is low
    step();
    clearLog();
    mem_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 9'h001, 1'b0, 32'h0);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checkOutput("stall_write", 32'(mem_write), 1);
      checkOutput("stall_addr", mem_addr, 32'h3FE);
      checkOutput("stall_sp", sp, 32'h3FE);
    end
    step();
    mem_ready = 1'b1;
    @(negedge clock);
    checkOutput("stall_release_write", 32'(mem_write), 1);
    @(negedge clock);
    checkOutput("stall_advanced", 32'(mem_write), 0);
    checkOutput("stall_count", log_addr.size(), 1);
    checkAccess("stall0", 0, 1'b1, 4'd0, 32'h3FE);
    waitDone(cycles);
    checkOutput("stall_done", cycles, 1);

    // Reset in the middle of a pop drops everything at once
    step();
    applyStimulus(1'b1, 1'b1, 9'h003, 1'b0, 32'h0);
    @(negedge clock);
    @(negedge clock);
    checkOutput("mid_read", 32'(mem_read), 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_sp", sp, 32'h3FF);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_read", 32'(mem_read), 0);
    step();
    reset = 1'b1;
    step();

    // start and sp_load together: start wins, SP untouched
    applyStimulus(1'b1, 1'b0, 9'h000, 1'b1, 32'h250);
    waitDone(cycles);
    checkOutput("prio_cycles", cycles, 2);
    checkOutput("prio_sp", sp, 32'h3FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
